// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit sequencer.
// Holds the FSM state encoding, PID nibble values and the PID byte builder.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PID  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam int PID_BITS = 8;

  // A PID travels on the wire as its nibble followed by the nibble's complement.
  function automatic logic [7:0] pid_byte(input logic [3:0] p);
    return {~p, p};
  endfunction

endpackage

// File: rtl/usb_tx_byte_serializer.sv
// Byte-to-bit shifter: emits shift[0] LSB-first and advances only when the
// downstream stuffer accepts the current bit.
module usb_tx_byte_serializer
  import usb_tx_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       active,
  input  logic       bs_ready,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       out_bit,
  output logic       byte_last_accepted
);

  localparam int IDX_W = $clog2(PID_BITS);

  logic [7:0]       shift;
  logic [IDX_W-1:0] bit_idx;
  logic             accept;

  assign accept             = active && bs_ready;
  assign byte_last_accepted = accept && (bit_idx == IDX_W'(PID_BITS - 1));
  assign out_bit            = shift[0];

  // A load always wins: it coincides with acceptance of the previous byte's last bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift   <= '0;
      bit_idx <= '0;
    end else if (load) begin
      shift   <= load_data;
      bit_idx <= '0;
    end else if (accept) begin
      shift   <= {1'b0, shift[7:1]};
      bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// Packet sequencer: PID then payload bytes, LSB-first, toward the CRC/stuffer.
// Optional statistics counters are built when USB_TX_SEQ_STATS_EN is defined.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter  int MAX_BYTES = 64,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pkt_start,
  input  logic [3:0]       pid,
  input  logic [CNT_W-1:0] nbytes,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             bs_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             pkt_done,
  output logic             underrun,
`ifdef USB_TX_SEQ_STATS_EN
  output logic [15:0]      pkt_count,
  output logic [15:0]      stall_count,
`endif
  output logic             start_err
);

  // Handshakes: a byte moves when byte_valid && byte_ready on a rising edge;
  // a bit moves when out_valid && bs_ready; otherwise both sides hold.

  state_t           state;
  logic [CNT_W-1:0] nbytes_q;
  logic [CNT_W-1:0] bytes_fetched;
  logic [CNT_W-1:0] bytes_sent;
  logic [7:0]       hold;
  logic             hold_full;

  logic             too_big;
  logic             fetch;
  logic             last_acc;
  logic             end_of_pkt;
  logic             ser_load;
  logic [7:0]       ser_data;

  assign too_big    = nbytes > CNT_W'(MAX_BYTES);
  assign byte_ready = ((state == PID) || (state == DATA)) && !hold_full &&
                      (bytes_fetched < nbytes_q);
  assign fetch      = byte_valid && byte_ready;
  // bytes_sent is 0 during PID, so this also covers zero-length packets.
  assign end_of_pkt = (bytes_sent == nbytes_q);
  assign busy       = (state != IDLE);

  always_comb begin
    ser_load = 1'b0;
    ser_data = hold;
    if (state == IDLE && pkt_start && !too_big) begin
      ser_load = 1'b1;
      ser_data = pid_byte(pid);
    end else if (last_acc && !end_of_pkt && hold_full) begin
      ser_load = 1'b1;
    end
  end

  usb_tx_byte_serializer u_ser (
    .clock              (clock),
    .reset_n            (reset_n),
    .active             (out_valid),
    .bs_ready           (bs_ready),
    .load               (ser_load),
    .load_data          (ser_data),
    .out_bit            (out_bit),
    .byte_last_accepted (last_acc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      pkt_done      <= 1'b0;
      underrun      <= 1'b0;
      start_err     <= 1'b0;
      nbytes_q      <= '0;
      bytes_fetched <= '0;
      bytes_sent    <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
    end else begin
      pkt_done  <= 1'b0;
      underrun  <= 1'b0;
      start_err <= 1'b0;

      if (fetch) begin
        hold          <= byte_data;
        hold_full     <= 1'b1;
        bytes_fetched <= bytes_fetched + 1'b1;
      end

      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          hold_full <= 1'b0;
          if (pkt_start) begin
            if (too_big) begin
              start_err <= 1'b1;
            end else begin
              nbytes_q      <= nbytes;
              bytes_fetched <= '0;
              bytes_sent    <= '0;
              out_valid     <= 1'b1;
              state         <= PID;
            end
          end
        end

        PID, DATA: begin
          if (last_acc) begin
            if (end_of_pkt) begin
              out_valid <= 1'b0;
              pkt_done  <= 1'b1;
              state     <= DONE;
            end else if (hold_full) begin
              // byte_ready is low while hold_full, so no fetch collides with this.
              hold_full  <= 1'b0;
              bytes_sent <= bytes_sent + 1'b1;
              state      <= DATA;
            end else begin
              out_valid <= 1'b0;
              underrun  <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        DONE: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef USB_TX_SEQ_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (pkt_done && pkt_count != 16'hFFFF)
        pkt_count <= pkt_count + 16'd1;
      if (out_valid && !bs_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
